// File: rtl/fp_mac_pkg.sv
// fp_mac_pkg: constants shared across the FP16 MAC datapath
package fp_mac_pkg;
    localparam int MANT_W = 11;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_SLL  = 2'd0;
    localparam mode_t MODE_SRL  = 2'd1;
    localparam mode_t MODE_SRA  = 2'd2;
    localparam mode_t MODE_NORM = 2'd3;
endpackage

// File: rtl/lzc_count.sv
// lzc_count: combinational leading-zero counter, all-zero input counts as WIDTH
module lzc_count #(
    parameter int WIDTH = 11,
    parameter int SHW   = 4
) (
    input  logic [WIDTH-1:0] data,
    output logic [SHW-1:0]   cnt
);
    always_comb begin
        cnt = SHW'(WIDTH);
        for (int i = 0; i < WIDTH; i++)
            if (data[i]) cnt = SHW'(WIDTH - 1 - i);
    end
endmodule

// File: rtl/fp_norm_shifter.sv
// fp_norm_shifter: two-stage valid/ready mantissa shifter with SLL/SRL/SRA/normalize modes
module fp_norm_shifter
    import fp_mac_pkg::*;
#(
    parameter int WIDTH = MANT_W,
    parameter int SHW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SHW-1:0]   out_shamt,
    output logic             out_sticky,
    output logic             out_ovf,
    output logic             out_zero
);
    localparam int NL = $clog2(WIDTH) + 1;

    logic             s1_valid, s2_valid, s2_adv, s1_sign;
    logic [WIDTH-1:0] s1_data, res;
    mode_t            s1_mode;
    logic [SHW-1:0]   s1_amt, lzc;
    logic [NL-1:0]    sat;
    logic             fill, is_left, res_sticky, res_ovf;
    logic [2*WIDTH-1:0] lf, rt;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign out_valid = s2_valid;

    lzc_count #(.WIDTH(WIDTH), .SHW(SHW)) u_lzc (.data(in_data), .cnt(lzc));

    // Saturating at WIDTH lets every level work in a 2*WIDTH window without losing shifted-out bits
    assign sat     = s1_amt >= SHW'(WIDTH) ? NL'(WIDTH) : NL'(s1_amt);
    assign fill    = s1_mode == MODE_SRA && s1_sign;
    assign is_left = s1_mode == MODE_SLL || s1_mode == MODE_NORM;

    for (genvar k = 0; k < NL; k++) begin : g_lvl
        logic [2*WIDTH-1:0] l_in, r_in, l, r;
        if (k == 0) begin : g_head
            assign l_in = {{WIDTH{1'b0}}, s1_data};
            assign r_in = {s1_data, {WIDTH{1'b0}}};
        end else begin : g_tail
            assign l_in = g_lvl[k-1].l;
            assign r_in = g_lvl[k-1].r;
        end
        assign l = sat[k] ? l_in << (2**k) : l_in;
        assign r = sat[k] ? {{(2**k){fill}}, r_in[2*WIDTH-1:2**k]} : r_in;
    end

    assign lf         = g_lvl[NL-1].l;
    assign rt         = g_lvl[NL-1].r;
    assign res        = is_left ? lf[WIDTH-1:0] : rt[2*WIDTH-1:WIDTH];
    assign res_ovf    = s1_mode == MODE_SLL && |lf[2*WIDTH-1:WIDTH];
    assign res_sticky = !is_left && |rt[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_mode    <= MODE_SLL;
            s1_amt     <= '0;
            s1_sign    <= 1'b0;
            s2_valid   <= 1'b0;
            out_data   <= '0;
            out_shamt  <= '0;
            out_sticky <= 1'b0;
            out_ovf    <= 1'b0;
            out_zero   <= 1'b0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (in_ready && in_valid) begin
                s1_data <= in_data;
                s1_mode <= in_mode;
                s1_amt  <= in_mode == MODE_NORM ? lzc : in_amt;
                s1_sign <= in_data[WIDTH-1];
            end
            if (s2_adv) s2_valid <= s1_valid;
            if (s2_adv && s1_valid) begin
                out_data   <= res;
                out_shamt  <= s1_amt;
                out_sticky <= res_sticky;
                out_ovf    <= res_ovf;
                out_zero   <= res == '0;
            end
        end
    end
endmodule

// File: tb/tb_fp_norm_shifter.sv
// tb_fp_norm_shifter: vector table plus scoreboard-checked streams, backpressure and reset cases
module tb_fp_norm_shifter;
    import fp_mac_pkg::*;
    localparam int W = 11, SHW = 4;

    typedef struct packed {
        logic [W-1:0]   data;
        logic [SHW-1:0] shamt;
        logic           sticky;
        logic           ovf;
        logic           zero;
    } res_t;
    typedef struct {
        logic [W-1:0]   d;
        logic [SHW-1:0] a;
        mode_t          m;
        res_t           e;
    } vec_t;

    logic clk, rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [SHW-1:0] in_amt, out_shamt;
    logic [1:0] in_mode;
    logic out_sticky, out_ovf, out_zero;
    res_t dut_res, drv_exp;
    res_t exp_q[$];
    int n_vec = 0, n_err = 0, cyc = 0;
    logic rand_ready = 1'b0;

    assign dut_res = {out_data, out_shamt, out_sticky, out_ovf, out_zero};

    fp_norm_shifter #(.WIDTH(W), .SHW(SHW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_shamt(out_shamt), .out_sticky(out_sticky), .out_ovf(out_ovf),
        .out_zero(out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(logic [W-1:0] d, logic [SHW-1:0] a, mode_t m);
        res_t r;
        int e;
        logic [127:0] w;
        logic f;
        r = '0;
        e = int'(a);
        f = (m == MODE_SRA) ? d[W-1] : 1'b0;
        if (m == MODE_NORM) begin
            e = W;
            for (int i = 0; i < W; i++) if (d[i]) e = W - 1 - i;
            r.data = d << e;
        end else if (m == MODE_SLL) begin
            w = 128'(d) << e;
            r.data = w[W-1:0];
            r.ovf = |w[127:W];
        end else begin
            for (int i = 0; i < W; i++) begin
                r.data[i] = (i + e < W) ? d[i + e] : f;
                if (i < e) r.sticky = r.sticky | d[i];
            end
        end
        r.shamt = SHW'(e);
        r.zero = r.data == '0;
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got %h expected no output", dut_res);
                end else if (out_ready) check("result", 64'(dut_res), 64'(exp_q.pop_front()));
                else check("stall_hold", 64'(dut_res), 64'(exp_q[0]));
            end
            if (in_valid && in_ready) exp_q.push_back(drv_exp);
        end
    end

    task automatic send(logic [W-1:0] d, logic [SHW-1:0] a, mode_t m, res_t e);
        logic acc;
        in_data = d;
        in_amt = a;
        in_mode = m;
        drv_exp = e;
        in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (t > 50) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
                break;
            end
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t tbl[14];
    vec_t bp[4];

    initial begin
        int t0, acc_n, idx;
        logic [W-1:0] d;
        logic [SHW-1:0] a;
        mode_t m;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_amt = '0;
        in_mode = MODE_SLL;
        out_ready = 1'b1;
        drv_exp = '0;
        tbl[0]  = '{11'h001, 4'd3,  MODE_SLL,  '{11'h008, 4'd3,  1'b0, 1'b0, 1'b0}};
        tbl[1]  = '{11'h401, 4'd12, MODE_SLL,  '{11'h000, 4'd12, 1'b0, 1'b1, 1'b1}};
        tbl[2]  = '{11'h405, 4'd2,  MODE_SRL,  '{11'h101, 4'd2,  1'b1, 1'b0, 1'b0}};
        tbl[3]  = '{11'h404, 4'd2,  MODE_SRL,  '{11'h101, 4'd2,  1'b0, 1'b0, 1'b0}};
        tbl[4]  = '{11'h600, 4'd4,  MODE_SRA,  '{11'h7E0, 4'd4,  1'b0, 1'b0, 1'b0}};
        tbl[5]  = '{11'h400, 4'd15, MODE_SRA,  '{11'h7FF, 4'd15, 1'b1, 1'b0, 1'b0}};
        tbl[6]  = '{11'h005, 4'd0,  MODE_NORM, '{11'h500, 4'd8,  1'b0, 1'b0, 1'b0}};
        tbl[7]  = '{11'h000, 4'd5,  MODE_NORM, '{11'h000, 4'd11, 1'b0, 1'b0, 1'b1}};
        tbl[8]  = '{11'h3FF, 4'd11, MODE_SRA,  '{11'h000, 4'd11, 1'b1, 1'b0, 1'b1}};
        tbl[9]  = '{11'h7FF, 4'd0,  MODE_SLL,  '{11'h7FF, 4'd0,  1'b0, 1'b0, 1'b0}};
        tbl[10] = '{11'h400, 4'd7,  MODE_NORM, '{11'h400, 4'd0,  1'b0, 1'b0, 1'b0}};
        tbl[11] = '{11'h7FF, 4'd10, MODE_SRL,  '{11'h001, 4'd10, 1'b1, 1'b0, 1'b0}};
        tbl[12] = '{11'h3FF, 4'd1,  MODE_SLL,  '{11'h7FE, 4'd1,  1'b0, 1'b0, 1'b0}};
        tbl[13] = '{11'h7FF, 4'd1,  MODE_SLL,  '{11'h7FE, 4'd1,  1'b0, 1'b1, 1'b0}};
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_outputs", 64'(dut_res), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) send(tbl[i].d, tbl[i].a, tbl[i].m, tbl[i].e);
        in_valid = 1'b0;
        drain();

        t0 = cyc;
        for (int i = 0; i < 40; i++) begin
            d = W'($urandom);
            a = SHW'($urandom_range(0, 15));
            m = mode_t'($urandom_range(0, 3));
            send(d, a, m, model(d, a, m));
        end
        in_valid = 1'b0;
        check("full_rate_cycles", 64'(cyc - t0), 64'd40);
        drain();

        rand_ready = 1'b1;
        fork
            while (rand_ready) begin
                @(posedge clk);
                #1;
                out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            end
        join_none
        for (int i = 0; i < 60; i++) begin
            d = W'($urandom);
            a = SHW'($urandom_range(0, 15));
            m = mode_t'($urandom_range(0, 3));
            send(d, a, m, model(d, a, m));
        end
        in_valid = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();

        bp[0] = '{11'h0F0, 4'd3, MODE_SRL,  '0};
        bp[1] = '{11'h012, 4'd0, MODE_NORM, '0};
        bp[2] = '{11'h455, 4'd5, MODE_SRA,  '0};
        bp[3] = '{11'h123, 4'd9, MODE_SLL,  '0};
        foreach (bp[i]) bp[i].e = model(bp[i].d, bp[i].a, bp[i].m);
        out_ready = 1'b0;
        acc_n = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 4) begin
                check("bp_accepts", 64'(acc_n), 64'd2);
                check("bp_in_ready", 64'(in_ready), 64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                out_ready = 1'b1;
            end
            idx = acc_n < 4 ? acc_n : 3;
            in_valid = acc_n < 4;
            in_data = bp[idx].d;
            in_amt = bp[idx].a;
            in_mode = bp[idx].m;
            drv_exp = bp[idx].e;
            @(negedge clk);
            if (c >= 4) check("bp_release_valid", 64'(out_valid), 64'd1);
            if (in_valid && in_ready) acc_n++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_total_accepts", 64'(acc_n), 64'd4);
        drain();

        out_ready = 1'b0;
        send(11'h0AA, 4'd2, MODE_SLL, model(11'h0AA, 4'd2, MODE_SLL));
        send(11'h155, 4'd3, MODE_SRL, model(11'h155, 4'd3, MODE_SRL));
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_idle", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(11'h005, 4'd0, MODE_NORM, model(11'h005, 4'd0, MODE_NORM));
        in_valid = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
